// File: rtl/change_payout_pkg.sv
// Shared vending-machine definitions for the coin-payout engine: state and coin-select
// encodings, default timing constants and timer sizing helpers.
package change_payout_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEject = 3'd1,
    StWait  = 3'd2,
    StGap   = 3'd3,
    StDone  = 3'd4,
    StFault = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CoinC1   = 2'd0,
    CoinC05  = 2'd1,
    CoinC025 = 2'd2
  } coin_e;

  localparam int unsigned DefPulseCyc   = 4;
  localparam int unsigned DefTimeoutCyc = 16;
  localparam int unsigned DefGapCyc     = 2;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned timer_width(int unsigned p, int unsigned t, int unsigned g);
    return $clog2(max3(p, t, g)) + 1;
  endfunction

endpackage

// File: rtl/payout_timer.sv
// Loadable down-counter with a zero flag; shared by the eject, wait and gap phases.
module payout_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         restart_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(negedge clk_i) begin
    if (restart_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/change_payout.sv
// Coin-payout engine: pays 1, 0.5 and 0.25 dollar coins one at a time, confirming each on the
// exit sensor, retrying on timeout and latching a fault when a hopper stays silent.
module change_payout #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PULSE_CYC   = change_payout_pkg::DefPulseCyc,
  parameter int unsigned TIMEOUT_CYC = change_payout_pkg::DefTimeoutCyc,
  parameter int unsigned GAP_CYC     = change_payout_pkg::DefGapCyc,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic             in_clka,
  input  logic             in_restart,
  input  logic             in_load,
  input  logic [CNT_W-1:0] in_change_1,
  input  logic             in_change_05,
  input  logic             in_change_025,
  input  logic             in_coin_seen,
  output logic             out_eject_1,
  output logic             out_eject_05,
  output logic             out_eject_025,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_fault,
  output logic [CNT_W-1:0] out_remaining_1
);
  import change_payout_pkg::*;

  localparam int unsigned TW = timer_width(PULSE_CYC, TIMEOUT_CYC, GAP_CYC);
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_1_q, rem_1_d;
  logic             rem_05_q, rem_05_d;
  logic             rem_025_q, rem_025_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             seen_q, seen_d;
  coin_e            sel;
  logic             owed;
  logic             confirm;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  payout_timer #(
    .W(TW)
  ) u_timer (
    .clk_i      (in_clka),
    .restart_i  (in_restart),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Highest denomination still owed is always the one being paid.
  always_comb begin
    if (rem_1_q != '0) begin
      sel = CoinC1;
    end else if (rem_05_q) begin
      sel = CoinC05;
    end else begin
      sel = CoinC025;
    end
  end

  assign owed = (rem_1_q != '0) || rem_05_q || rem_025_q;

  always_comb begin
    state_d   = state_q;
    rem_1_d   = rem_1_q;
    rem_05_d  = rem_05_q;
    rem_025_d = rem_025_q;
    retry_d   = retry_q;
    seen_d    = seen_q;
    confirm   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    unique case (state_q)
      StIdle: begin
        if (in_load) begin
          rem_1_d   = in_change_1;
          rem_05_d  = in_change_05;
          rem_025_d = in_change_025;
          retry_d   = '0;
          seen_d    = 1'b0;
          if ((in_change_1 == '0) && !in_change_05 && !in_change_025) begin
            state_d = StDone;
          end else begin
            state_d  = StEject;
            tmr_load = 1'b1;
            tmr_val  = TW'(PULSE_CYC - 1);
          end
        end
      end
      StEject: begin
        // A sensor edge on the final pulse cycle still counts for this coin.
        seen_d = seen_q | in_coin_seen;
        if (tmr_zero) begin
          if (seen_d) begin
            confirm = 1'b1;
          end else begin
            state_d  = StWait;
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT_CYC - 1);
          end
        end
      end
      StWait: begin
        if (in_coin_seen) begin
          confirm = 1'b1;
        end else if (tmr_zero) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d  = retry_q + RW'(1);
            state_d  = StEject;
            seen_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = TW'(PULSE_CYC - 1);
          end else begin
            state_d = StFault;
          end
        end
      end
      StGap: begin
        if (tmr_zero) begin
          if (owed) begin
            state_d  = StEject;
            seen_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = TW'(PULSE_CYC - 1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    if (confirm) begin
      state_d  = StGap;
      retry_d  = '0;
      tmr_load = 1'b1;
      tmr_val  = TW'(GAP_CYC - 1);
      case (sel)
        CoinC1: begin
          if (rem_1_q != '0) begin
            rem_1_d = rem_1_q - CNT_W'(1);
          end
        end
        CoinC05: rem_05_d  = 1'b0;
        default: rem_025_d = 1'b0;
      endcase
    end
  end

  always_ff @(negedge in_clka) begin
    if (in_restart) begin
      state_q   <= StIdle;
      rem_1_q   <= '0;
      rem_05_q  <= 1'b0;
      rem_025_q <= 1'b0;
      retry_q   <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_1_q   <= rem_1_d;
      rem_05_q  <= rem_05_d;
      rem_025_q <= rem_025_d;
      retry_q   <= retry_d;
      seen_q    <= seen_d;
    end
  end

  assign out_eject_1     = (state_q == StEject) && (sel == CoinC1);
  assign out_eject_05    = (state_q == StEject) && (sel == CoinC05);
  assign out_eject_025   = (state_q == StEject) && (sel == CoinC025);
  assign out_busy        = (state_q != StIdle) && (state_q != StFault);
  assign out_done        = (state_q == StDone);
  assign out_fault       = (state_q == StFault);
  assign out_remaining_1 = rem_1_q;

endmodule

// File: tb/tb_change_payout.sv
// Bench for change_payout: a per-cycle expected trace is built from the payout rules
// (pulse, wait, gap, retry, fault) and compared against the DUT every cycle.
module tb_change_payout;

  localparam int P    = 4;
  localparam int T    = 16;
  localparam int G    = 2;
  localparam int MR   = 2;
  localparam int CW   = 8;
  localparam int NONE = 1000;

  logic          in_clka = 1'b0;
  logic          in_restart, in_load, in_change_05, in_change_025, in_coin_seen;
  logic [CW-1:0] in_change_1;
  logic          out_eject_1, out_eject_05, out_eject_025;
  logic          out_busy, out_done, out_fault;
  logic [CW-1:0] out_remaining_1;

  typedef struct packed {
    logic [2:0]    ej;
    logic          busy;
    logic          done;
    logic          fault;
    logic [CW-1:0] rem;
  } obs_t;

  obs_t exp_q[$];
  bit   seen_plan[$];
  int   force_d[$];
  int   reload_at = -1;
  int   checks = 0;
  int   errors = 0;

  change_payout #(
    .CNT_W       (CW),
    .PULSE_CYC   (P),
    .TIMEOUT_CYC (T),
    .GAP_CYC     (G),
    .MAX_RETRY   (MR)
  ) dut (
    .in_clka         (in_clka),
    .in_restart      (in_restart),
    .in_load         (in_load),
    .in_change_1     (in_change_1),
    .in_change_05    (in_change_05),
    .in_change_025   (in_change_025),
    .in_coin_seen    (in_coin_seen),
    .out_eject_1     (out_eject_1),
    .out_eject_05    (out_eject_05),
    .out_eject_025   (out_eject_025),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_fault       (out_fault),
    .out_remaining_1 (out_remaining_1)
  );

  always #5 in_clka = ~in_clka;

  task automatic chk(input string tag, input int cyc, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic chk_obs(input int cyc, input obs_t e);
    chk("eject", cyc, {29'd0, out_eject_1, out_eject_05, out_eject_025}, {29'd0, e.ej});
    chk("busy", cyc, {31'd0, out_busy}, {31'd0, e.busy});
    chk("done", cyc, {31'd0, out_done}, {31'd0, e.done});
    chk("fault", cyc, {31'd0, out_fault}, {31'd0, e.fault});
    chk("remaining_1", cyc, {24'd0, out_remaining_1}, {24'd0, e.rem});
  endtask

  // Sensor delay in cycles after the eject rises; NONE means the coin never shows up.
  function automatic int pick_delay();
    int r;
    if (force_d.size() > 0) return force_d.pop_front();
    r = $urandom_range(0, 9);
    if (r < 5) return $urandom_range(0, P - 1);
    if (r < 8) return $urandom_range(P, P + T - 1);
    return NONE;
  endfunction

  task automatic push(input logic [2:0] ej, input logic busy, input logic done,
                      input logic fault, input int rem, input bit seen);
    obs_t o;
    o.ej = ej; o.busy = busy; o.done = done; o.fault = fault; o.rem = CW'(rem);
    exp_q.push_back(o);
    seen_plan.push_back(seen);
  endtask

  task automatic build_plan(input int n1, input bit h05, input bit h025, output bit faulted);
    int   coins[$];
    int   rem1, retry, d;
    bit   ok, dbl;
    logic [2:0] eh;
    exp_q.delete();
    seen_plan.delete();
    faulted = 1'b0;
    rem1 = n1;
    for (int i = 0; i < n1; i++) coins.push_back(1);
    if (h05) coins.push_back(2);
    if (h025) coins.push_back(3);
    foreach (coins[c]) begin
      if (faulted) break;
      eh = (coins[c] == 1) ? 3'b100 : (coins[c] == 2) ? 3'b010 : 3'b001;
      retry = 0;
      ok = 1'b0;
      while (!ok && !faulted) begin
        d = pick_delay();
        dbl = (d + 1 < P) && ($urandom_range(0, 3) == 0);
        for (int j = 0; j < P; j++) push(eh, 1, 0, 0, rem1, (j == d) || (dbl && j == d + 1));
        if (d < P) begin
          ok = 1'b1;
        end else if (d < P + T) begin
          for (int j = P; j <= d; j++) push(3'b000, 1, 0, 0, rem1, j == d);
          ok = 1'b1;
        end else begin
          for (int j = 0; j < T; j++) push(3'b000, 1, 0, 0, rem1, 0);
          if (retry < MR) retry++;
          else faulted = 1'b1;
        end
        if (ok) begin
          if (coins[c] == 1) rem1--;
          for (int j = 0; j < G; j++) push(3'b000, 1, 0, 0, rem1, $urandom_range(0, 3) == 0);
        end
      end
    end
    if (faulted) begin
      for (int j = 0; j < 4; j++) push(3'b000, 0, 0, 1, rem1, $urandom_range(0, 1) == 1);
    end else begin
      push(3'b000, 1, 1, 0, rem1, $urandom_range(0, 1) == 1);
      push(3'b000, 0, 0, 0, rem1, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic run_plan(input int n1, input bit h05, input bit h025, input int stop_at,
                          output bit faulted, output int done_at);
    build_plan(n1, h05, h025, faulted);
    done_at = -1;
    in_coin_seen  = 1'b0;
    in_load       = 1'b1;
    in_change_1   = CW'(n1);
    in_change_05  = h05;
    in_change_025 = h025;
    for (int j = 0; j < exp_q.size() && j < stop_at; j++) begin
      @(posedge in_clka);
      in_load = 1'b0;
      if (out_done === 1'b1 && done_at < 0) done_at = j;
      chk_obs(j, exp_q[j]);
      in_coin_seen = seen_plan[j];
      if (j == reload_at) begin
        in_load     = 1'b1;
        in_change_1 = CW'(5);
      end
    end
  endtask

  task automatic do_reset();
    in_restart   = 1'b1;
    in_load      = 1'b0;
    in_coin_seen = 1'b0;
    @(posedge in_clka);
    @(posedge in_clka);
    in_restart = 1'b0;
  endtask

  initial begin
    bit   f;
    int   d;
    obs_t zero_o;
    obs_t fault_o;
    zero_o  = '0;
    fault_o = '0;
    fault_o.fault = 1'b1;
    fault_o.rem   = CW'(1);
    in_change_1   = '0;
    in_change_05  = 1'b0;
    in_change_025 = 1'b0;

    do_reset();
    chk_obs(-1, zero_o);

    // Two dollars and a half, sensed one cycle into each pulse.
    force_d = '{1, 1, 1};
    run_plan(2, 1'b1, 1'b0, NONE, f, d);
    chk("done_latency_3coins", 0, d, 3 * (P + G));

    // Empty request completes at once.
    force_d.delete();
    run_plan(0, 1'b0, 1'b0, NONE, f, d);
    chk("done_latency_zero", 0, d, 0);

    // Quarter: first pulse unseen, second seen three cycles into its wait.
    force_d = '{NONE, P + 3};
    run_plan(0, 1'b0, 1'b1, NONE, f, d);

    // Silent hopper: three pulses then a sticky fault that ignores new loads.
    force_d = '{NONE, NONE, NONE};
    run_plan(1, 1'b0, 1'b0, NONE, f, d);
    in_load     = 1'b1;
    in_change_1 = CW'(5);
    @(posedge in_clka);
    in_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_obs(100 + i, fault_o);
      @(posedge in_clka);
    end
    do_reset();
    chk_obs(-1, zero_o);

    // Restart during the second dollar abandons the payout.
    force_d = '{1, 1, 1};
    run_plan(3, 1'b0, 1'b0, P + G + 2, f, d);
    in_restart   = 1'b1;
    in_coin_seen = 1'b0;
    @(posedge in_clka);
    in_restart = 1'b0;
    chk_obs(-2, zero_o);
    force_d = '{1};
    run_plan(0, 1'b1, 1'b0, NONE, f, d);

    // A second load during EJECT is dropped.
    force_d   = '{1};
    reload_at = 1;
    run_plan(1, 1'b0, 1'b0, NONE, f, d);
    reload_at = -1;

    // Randomized requests and sensor timing.
    for (int k = 0; k < 25; k++) begin
      force_d.delete();
      run_plan($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               NONE, f, d);
      if (f) begin
        do_reset();
        chk_obs(-1, zero_o);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
